// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding the dual-mode ALU; writes the ALU result back to a local register file on retire.
// Latency: in_uop -> alu_* is 1 cycle; ALU result lands in the register file at the fire edge, visible on wb_* 1 cycle later.
// Backpressure: single output register; in_ready = !out_valid | out_ready, gated by flush and (without ALU_ISSUE_BYPASS_EN) by RAW hazards.
module alu_issue_stage #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_uop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_mode,
  output logic [2:0]        alu_opa,
  output logic [2:0]        alu_opb,
  output logic [5:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  // Register indices are 4 bits; compare in 5 bits so NREGS=16 is representable.
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  // Micro-op field decode.
  logic       uop_mode;
  logic [2:0] uop_opa;
  logic [2:0] uop_opb;
  logic [5:0] uop_ctrl;
  logic [3:0] uop_rd;
  logic [3:0] uop_rs1;
  logic [3:0] uop_rs2;
  logic       uop_use_imm;
  logic [5:0] uop_imm6;

  assign uop_mode    = in_uop[31];
  assign uop_opa     = in_uop[30:28];
  assign uop_opb     = in_uop[27:25];
  assign uop_ctrl    = in_uop[24:19];
  assign uop_rd      = in_uop[18:15];
  assign uop_rs1     = in_uop[14:11];
  assign uop_rs2     = in_uop[10:7];
  assign uop_use_imm = in_uop[6];
  assign uop_imm6    = in_uop[5:0];

  // State: output register, writeback observability, register file.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_mode_q, alu_mode_d;
  logic [2:0]        alu_opa_q, alu_opa_d;
  logic [2:0]        alu_opb_q, alu_opb_d;
  logic [5:0]        alu_ctrl_q, alu_ctrl_d;
  logic [3:0]        out_rd_q, out_rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  // An index names a real, writable register: not r0 and inside the file.
  function automatic logic idx_live(input logic [3:0] idx);
    return (idx != 4'd0) && ({1'b0, idx} < NREGS_L);
  endfunction

  logic              rs1_live;
  logic              rs2_live;
  logic              dst_live;
  logic [DATA_W-1:0] rs1_rf;
  logic [DATA_W-1:0] rs2_rf;
  logic              haz_rs1;
  logic              haz_rs2;
  logic              fire;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  // Register-file read ports and RAW hazard detection against the held op.
  always_comb begin
    rs1_live = idx_live(uop_rs1);
    rs2_live = idx_live(uop_rs2);
    dst_live = idx_live(out_rd_q);
    rs1_rf   = rs1_live ? rf_q[uop_rs1] : '0;
    rs2_rf   = rs2_live ? rf_q[uop_rs2] : '0;
    haz_rs1  = out_valid_q && dst_live && (uop_rs1 == out_rd_q);
    haz_rs2  = out_valid_q && dst_live && !uop_use_imm && (uop_rs2 == out_rd_q);
    // flush kills the held op, so it can neither retire nor make room.
    fire     = out_valid_q && out_ready && !flush;
  end

`ifdef ALU_ISSUE_BYPASS_EN
  // Bypass build: a hazarding operand comes straight from the ALU; a hazard can
  // only be accepted together with the producer's fire, so alu_result is the value.
  always_comb begin
    in_ready = !flush && (!out_valid_q || out_ready);
    opnd_a   = haz_rs1 ? alu_result : rs1_rf;
    opnd_b   = uop_use_imm ? {{(DATA_W-6){1'b0}}, uop_imm6}
                           : (haz_rs2 ? alu_result : rs2_rf);
  end
`else
  // Stall build: hold off a dependent op until the producer has retired; it then
  // reads the freshly written register one cycle later (one bubble).
  always_comb begin
    in_ready = !flush && (!out_valid_q || out_ready) && !(haz_rs1 || haz_rs2);
    opnd_a   = rs1_rf;
    opnd_b   = uop_use_imm ? {{(DATA_W-6){1'b0}}, uop_imm6} : rs2_rf;
  end
`endif

  assign accept = in_valid && in_ready;

  // Next-state: load on accept, retire/writeback on fire, drop on flush.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_mode_d  = alu_mode_q;
    alu_opa_d   = alu_opa_q;
    alu_opb_d   = alu_opb_q;
    alu_ctrl_d  = alu_ctrl_q;
    out_rd_d    = out_rd_q;
    wb_valid_d  = fire;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    rf_d        = rf_q;

    if (accept) begin
      // in_ready is low during flush, so accept never coincides with it.
      out_valid_d = 1'b1;
      alu_a_d     = opnd_a;
      alu_b_d     = opnd_b;
      alu_mode_d  = uop_mode;
      alu_opa_d   = uop_opa;
      alu_opb_d   = uop_opb;
      alu_ctrl_d  = uop_ctrl;
      out_rd_d    = uop_rd;
    end else if (fire || flush) begin
      out_valid_d = 1'b0;
    end

    if (fire) begin
      wb_rd_d   = out_rd_q;
      wb_data_d = alu_result;
      if (dst_live) begin
        rf_d[out_rd_q] = alu_result;
      end
    end
  end

  // Output register and writeback observability flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= 1'b0;
      alu_opa_q   <= '0;
      alu_opb_q   <= '0;
      alu_ctrl_q  <= '0;
      out_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_mode_q  <= alu_mode_d;
      alu_opa_q   <= alu_opa_d;
      alu_opb_q   <= alu_opb_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_rd_q    <= out_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Register file; cleared by reset so an in-flight result never survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_mode  = alu_mode_q;
  assign alu_opa   = alu_opa_q;
  assign alu_opb   = alu_opb_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
